imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder for the Fetch stage's CPU-memory interface. Accepts one word-aligned instruction address per cycle on the `iaddr`/`iaddr_vld` request channel. Returns the addressed 32-bit word on `inst`/`inst_vld` after a fixed, parameterised latency. Also provides a backdoor write port so the bench or boot loader can preload program memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, request address width
- `INST_WIDTH`, 32, instruction word width
- `DEPTH_WORDS`, 4096, memory depth in words; power of two
- `BASE_ADDR`, 32'h0000_0000, byte address mapped to word 0; must be 4-byte aligned
- `LATENCY`, 1, request-to-response delay in cycles; legal range 1..4
- `ERR_INST`, 32'h0000_0013, word returned on a faulting request (NOP)

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `i_iaddr`  in  ADDR_WIDTH  request byte address; don't-care (may be Z/X) while `i_iaddr_vld`=0
- `i_iaddr_vld`  in  1  request valid; sampled every cycle, no backpressure
- `o_inst`  out  INST_WIDTH  response instruction word
- `o_inst_vld`  out  1  response valid, one-cycle pulse per request
- `o_inst_err`  out  1  qualifies `o_inst_vld`; request was misaligned or out of range
- `i_wr_en`  in  1  backdoor write strobe
- `i_wr_idx`  in  $clog2(DEPTH_WORDS)  backdoor word index
- `i_wr_data`  in  INST_WIDTH  backdoor write data
- `o_req_cnt`  out  32  count of accepted requests, saturating

## Operation
- **Request acceptance:** every cycle with `i_iaddr_vld`=1 is accepted, including back-to-back cycles. There is no ready signal. Sustained throughput is 1 request/cycle.
- **Decode**, performed in the acceptance cycle:
  - `offset = i_iaddr - BASE_ADDR`, computed modulo 2^ADDR_WIDTH.
  - Misaligned if `i_iaddr[1:0]` != 0.
  - Out of range if `offset >= DEPTH_WORDS*4` (unsigned compare). Addresses below `BASE_ADDR` wrap and therefore fault.
  - Word index is `offset[$clog2(DEPTH_WORDS)+1:2]`.
- **Memory read:** happens in the acceptance cycle. Data, valid and err travel through a LATENCY-deep shift pipeline. Stage 1 is the array read register; stages 2..LATENCY are plain delay registers.
- **Faulting request:** response carries `o_inst`=ERR_INST and `o_inst_err`=1. The memory is not read.
- **Idle cycles:** a cycle with `i_iaddr_vld`=0 inserts a bubble: `o_inst_vld`=0 LATENCY cycles later. `o_inst` and `o_inst_err` hold their previous values during bubbles.
- **Backdoor write:**
  - With `i_wr_en`=1, `mem[i_wr_idx] <= i_wr_data` at the clock edge.
  - Writes are unaffected by reset; memory contents are not cleared.
- **Read/write collision:** a same-cycle read and write to the same word use read-before-write. The response carries the old word; the new word is visible to requests from the next cycle.
- **Request counter:** `o_req_cnt` increments on every accepted request, including faulting ones. It saturates at 32'hFFFF_FFFF.
- **Reset:** while `rst_n`=0 at a clock edge, all pipeline valids are cleared, so in-flight responses are discarded and never emitted. Requests presented in the reset cycle are ignored.

## Timing
- **Reset values**, one edge after `rst_n`=0:
  - `o_inst_vld`=0
  - `o_inst`=0
  - `o_inst_err`=0
  - `o_req_cnt`=0
  - all pipeline stages invalid
- **Latency:** a request accepted at the edge ending cycle t produces `o_inst_vld`=1 during cycle t+LATENCY. Valid is high for exactly one cycle per request.
- **Ordering:** responses leave strictly in request order with no reordering or merging. The `o_inst_vld` pattern equals the `i_iaddr_vld` pattern delayed by LATENCY.
- **First request after reset:** the first request accepted in the first cycle with `rst_n`=1 responds at cycle LATENCY after that cycle. This covers the Fetch stage's reset-deassert address strobe.
- **Counter timing:** `o_req_cnt` updates at the same edge that accepts the request.
- **Backdoor write timing:** a write at edge e is readable by a request accepted at edge e+1.

## Test plan
- **Preload and stream:** LATENCY=1. Preload mem[0..3]=32'h11,22,33,44. Issue 0x0,0x4,0x8,0xC back-to-back → `o_inst_vld`=1 for 4 consecutive cycles starting 1 cycle later, with data 11,22,33,44, `o_inst_err`=0, `o_req_cnt`=4.
- **Bubbles and latency:** LATENCY=3. Issue the pattern vld=1,0,1 at addresses 0x0,–,0x8 → `o_inst_vld` pattern 1,0,1 starting 3 cycles later, data mem[0], held, mem[2].
- **Faults:**
  - Request 0x6 (misaligned) → ERR_INST=0x00000013 with err=1.
  - With BASE_ADDR=0x1000, request 0x0FFC → err=1.
  - Request 0x1000+DEPTH_WORDS*4 → err=1.
  - Request 0x1000 → mem[0] with err=0.
- **Collision:** write mem[5]=0xAA while requesting 0x14 in the same cycle → old value returned. Request 0x14 next cycle → 0xAA.
- **Reset mid-flight:** LATENCY=4 with 3 requests in flight. Pulse `rst_n`=0 for one cycle → no `o_inst_vld` for those requests, all outputs 0, `o_req_cnt`=0. Memory contents are preserved: a subsequent request to 0x0 returns the preloaded word.
- **Counter saturation:** force `o_req_cnt` to 32'hFFFF_FFFE, then issue 3 requests → counter ends at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: decodes one fetch address per cycle and returns the
// addressed word (or a fault NOP) through a fixed-latency pipeline, with a backdoor preload port.
module imem_responder #(
    parameter int                     ADDR_WIDTH  = 32,
    parameter int                     INST_WIDTH  = 32,
    parameter int                     DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 32'h0000_0000,
    parameter int                     LATENCY     = 1,
    parameter logic [INST_WIDTH-1:0]  ERR_INST    = 32'h0000_0013
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          i_iaddr,
    input  logic                           i_iaddr_vld,
    output logic [INST_WIDTH-1:0]          o_inst,
    output logic                           o_inst_vld,
    output logic                           o_inst_err,
    input  logic                           i_wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_wr_idx,
    input  logic [INST_WIDTH-1:0]          i_wr_data,
    output logic [31:0]                    o_req_cnt
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [INST_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0] offset;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  fault;
    logic [IDX_W-1:0]      rd_idx;
    logic [INST_WIDTH-1:0] stage1_data_d;

    logic [INST_WIDTH-1:0] data_q [LATENCY];
    logic [LATENCY-1:0]    vld_q;
    logic [LATENCY-1:0]    err_q;
    logic [31:0]           req_cnt_q;
    logic [31:0]           req_cnt_d;

    // Depth is a power of two, so "offset >= DEPTH_WORDS*4" reduces to any bit set above
    // the word-index field; this also makes addresses below BASE_ADDR (wrapped) fault.
    always_comb begin
        offset        = i_iaddr - BASE_ADDR;
        misaligned    = (i_iaddr[1:0] != 2'b00);
        out_of_range  = |offset[ADDR_WIDTH-1:IDX_W+2];
        fault         = misaligned | out_of_range;
        rd_idx        = offset[IDX_W+1:2];
        stage1_data_d = fault ? ERR_INST : mem[rd_idx];
    end

    always_comb begin
        req_cnt_d = req_cnt_q;
        if (i_iaddr_vld && (req_cnt_q != 32'hFFFF_FFFF)) begin
            req_cnt_d = req_cnt_q + 32'd1;
        end
    end

    // Program memory is never reset; non-blocking write gives read-before-write on collision.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Data/err only advance behind a valid, so the output holds its last response in bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q     <= '0;
            err_q     <= '0;
            req_cnt_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q[0]  <= i_iaddr_vld;
            req_cnt_q <= req_cnt_d;
            if (i_iaddr_vld) begin
                data_q[0] <= stage1_data_d;
                err_q[0]  <= fault;
            end
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                    err_q[k]  <= err_q[k-1];
                end
            end
        end
    end

    assign o_inst     = data_q[LATENCY-1];
    assign o_inst_vld = vld_q[LATENCY-1];
    assign o_inst_err = err_q[LATENCY-1];
    assign o_req_cnt  = req_cnt_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: three responders (latency 1/3/4, base 0/0/0x1000) share one stimulus
// stream; a reference model predicts every response and the cycle it must appear in.
module tb_imem_responder;

    localparam int DEPTH = 64;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] iaddr;
    logic        iaddr_vld;
    logic        wr_en;
    logic [5:0]  wr_idx;
    logic [31:0] wr_data;

    logic [31:0] inst0, inst1, inst2;
    logic        vld0, vld1, vld2;
    logic        err0, err1, err2;
    logic [31:0] cnt0, cnt1, cnt2;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;

    logic [31:0] mem_m [DEPTH];
    exp_t        sb [3][$];
    logic [31:0] last_data [3];
    logic        last_err [3];
    logic [31:0] cnt_m [3];
    int          lat [3];
    logic [31:0] base [3];

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_iaddr(iaddr), .i_iaddr_vld(iaddr_vld),
        .o_inst(inst0), .o_inst_vld(vld0), .o_inst_err(err0),
        .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_data(wr_data), .o_req_cnt(cnt0));

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(32'h0)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_iaddr(iaddr), .i_iaddr_vld(iaddr_vld),
        .o_inst(inst1), .o_inst_vld(vld1), .o_inst_err(err1),
        .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_data(wr_data), .o_req_cnt(cnt1));

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .BASE_ADDR(32'h1000)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_iaddr(iaddr), .i_iaddr_vld(iaddr_vld),
        .o_inst(inst2), .o_inst_vld(vld2), .o_inst_err(err2),
        .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_data(wr_data), .o_req_cnt(cnt2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [32:0] model_rd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] off;
        off = a - b;
        if (a[1:0] != 2'b00 || off >= 32'(DEPTH * 4)) return {1'b1, 32'h0000_0013};
        return {1'b0, mem_m[off[7:2]]};
    endfunction

    task automatic mon(input int d, input logic vld, input logic [31:0] inst,
                       input logic err, input logic [31:0] cnt);
        logic exp_vld;
        exp_t e;
        while (sb[d].size() > 0 && sb[d][0].due < cyc) void'(sb[d].pop_front());
        exp_vld = (sb[d].size() > 0 && sb[d][0].due == cyc);
        chk($sformatf("vld%0d", d), {31'b0, vld}, {31'b0, exp_vld});
        if (exp_vld) begin
            e = sb[d].pop_front();
            chk($sformatf("data%0d", d), inst, e.data);
            chk($sformatf("err%0d", d), {31'b0, err}, {31'b0, e.err});
            last_data[d] = e.data;
            last_err[d]  = e.err;
        end else begin
            chk($sformatf("hold_data%0d", d), inst, last_data[d]);
            chk($sformatf("hold_err%0d", d), {31'b0, err}, {31'b0, last_err[d]});
        end
        chk($sformatf("cnt%0d", d), cnt, cnt_m[d]);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        mon(0, vld0, inst0, err0, cnt0);
        mon(1, vld1, inst1, err1, cnt1);
        mon(2, vld2, inst2, err2, cnt2);
    endtask

    // Drive one cycle of stimulus; expectations are computed before the write lands.
    task automatic drive(input logic v, input logic [31:0] a, input logic we,
                         input logic [5:0] wi, input logic [31:0] wd);
        logic [32:0] r;
        exp_t e;
        iaddr_vld = v;
        iaddr     = v ? a : $urandom;
        wr_en     = we;
        wr_idx    = wi;
        wr_data   = wd;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                sb[d].delete();
                last_data[d] = '0;
                last_err[d]  = 1'b0;
                cnt_m[d]     = '0;
            end else if (v) begin
                r      = model_rd(a, base[d]);
                e.due  = cyc + lat[d];
                e.data = r[31:0];
                e.err  = r[32];
                sb[d].push_back(e);
                if (cnt_m[d] != 32'hFFFF_FFFF) cnt_m[d] = cnt_m[d] + 1;
            end
        end
        if (we) mem_m[wi] = wd;
        step();
    endtask

    task automatic req(input logic [31:0] a);
        drive(1'b1, a, 1'b0, 6'd0, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0, 6'd0, 32'd0);
    endtask

    initial begin
        lat  = '{1, 3, 4};
        base = '{32'h0, 32'h0, 32'h1000};
        for (int d = 0; d < 3; d++) begin
            last_data[d] = '0;
            last_err[d]  = 1'b0;
            cnt_m[d]     = '0;
        end
        rst_n = 1'b0;
        iaddr_vld = 1'b0;
        iaddr = '0;
        wr_en = 1'b0;
        wr_idx = '0;
        wr_data = '0;
        @(negedge clk);

        // reset: requests in reset cycles are ignored
        drive(1'b1, 32'h0, 1'b0, 6'd0, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 6'd0, 32'd0);
        rst_n = 1'b1;

        // preload whole array while idle
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] w;
            case (i)
                0: w = 32'h11;
                1: w = 32'h22;
                2: w = 32'h33;
                3: w = 32'h44;
                default: w = 32'hC0DE_0000 + 32'(i * 7);
            endcase
            drive(1'b0, 32'h0, 1'b1, 6'(i), w);
        end

        // back-to-back stream
        req(32'h0); req(32'h4); req(32'h8); req(32'hC);
        idle(5);

        // bubble pattern
        req(32'h0); idle(1); req(32'h8);
        idle(5);

        // faults and range boundaries
        req(32'h6); req(32'h0FFC); req(32'h1000 + DEPTH * 4); req(32'h1000);
        req(32'h1008); req(32'hFC); req(32'h100); req(32'h10FC); req(32'h1001);
        idle(5);

        // read/write collision on word 5
        drive(1'b1, 32'h14, 1'b1, 6'd5, 32'hAA);
        req(32'h14);
        drive(1'b1, 32'h1014, 1'b1, 6'd5, 32'hBB);
        req(32'h1014);
        idle(5);

        // reset with requests in flight
        req(32'h0); req(32'h4); req(32'h1000);
        rst_n = 1'b0;
        drive(1'b1, 32'h8, 1'b0, 6'd0, 32'd0);
        rst_n = 1'b1;
        req(32'h0); req(32'h1000);
        idle(5);

        // counter saturation
        force dut0.req_cnt_q = 32'hFFFF_FFFE;
        force dut1.req_cnt_q = 32'hFFFF_FFFE;
        force dut2.req_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut0.req_cnt_q;
        release dut1.req_cnt_q;
        release dut2.req_cnt_q;
        for (int d = 0; d < 3; d++) cnt_m[d] = 32'hFFFF_FFFE;
        req(32'h4); req(32'h1004); req(32'h8);
        idle(5);
        chk("cnt_sat", cnt0, 32'hFFFF_FFFF);

        // mixed random traffic including writes and faults
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                1: a = 32'h1000 + (32'($urandom_range(0, DEPTH - 1)) << 2);
                2: a = 32'($urandom_range(0, 32'h1200));
                3: a = 32'h1000 + 32'(DEPTH * 4) + (32'($urandom_range(0, 3)) << 2);
                4: a = 32'h0FF0 + (32'($urandom_range(0, 3)) << 2);
                default: a = 32'(DEPTH * 4 - 4);
            endcase
            drive(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, DEPTH - 1)), $urandom);
        end
        idle(6);

        for (int d = 0; d < 3; d++) chk($sformatf("drain%0d", d), 32'(sb[d].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
